// File: rtl/gates_pkg.sv
// Shared types for the registered gate pipeline: opcode encoding and the
// flag pair stored alongside every result in the output FIFO.
package gates_pkg;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NOTA  = 3'd2,
        OP_XOR   = 3'd3,
        OP_NAND  = 3'd4,
        OP_NOR   = 3'd5,
        OP_XNOR  = 3'd6,
        OP_PASSB = 3'd7
    } op_t;

    // Width-independent part of a result entry; the WIDTH-bit y field is
    // added by the parameterised entry struct inside gates_pipe.
    typedef struct packed {
        logic zero;
        logic parity;
    } flags_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered occupancy count; push when full and pop
// when empty are silently dropped.
module sync_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          wdata,
    output logic [DATA_W-1:0]          rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/gates_pipe.sv
// Registered bitwise-operation pipeline with optional accumulate mode; results
// and their zero/parity flags are queued in an output FIFO for a stallable consumer.
module gates_pipe
    import gates_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [2:0]                 op,
    input  logic                       acc_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           y,
    output logic                       zero,
    output logic                       parity,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        flags_t           flags;
    } entry_t;

    op_t              op_sel;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opnd_a;
    logic [WIDTH-1:0] result;
    logic             accept;
    logic             full;
    logic             empty;
    entry_t           wr_entry;
    entry_t           rd_entry;

    // in_ready comes only from the registered FIFO count, never from out_ready.
    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign op_sel   = op_t'(op);
    assign opnd_a   = acc_en ? acc : a;

    always_comb begin
        result = '0;
        case (op_sel)
            OP_AND:   result = opnd_a & b;
            OP_OR:    result = opnd_a | b;
            OP_NOTA:  result = ~opnd_a;
            OP_XOR:   result = opnd_a ^ b;
            OP_NAND:  result = ~(opnd_a & b);
            OP_NOR:   result = ~(opnd_a | b);
            OP_XNOR:  result = ~(opnd_a ^ b);
            OP_PASSB: result = b;
            default:  result = '0;
        endcase
    end

    assign wr_entry.y            = result;
    assign wr_entry.flags.zero   = (result == '0);
    assign wr_entry.flags.parity = ^result;

    // The accumulator follows every accepted result so acc_en can chain with no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= result;
        end
    end

    sync_fifo #(
        .DATA_W ($bits(entry_t)),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (out_ready),
        .wdata (wr_entry),
        .rdata (rd_entry),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Head outputs are forced to zero when empty rather than showing stale storage.
    assign out_valid = !empty;
    assign y         = empty ? '0 : rd_entry.y;
    assign zero      = empty ? 1'b0 : rd_entry.flags.zero;
    assign parity    = empty ? 1'b0 : rd_entry.flags.parity;

endmodule

// File: tb/tb_gates_pipe.sv
// Self-checking bench for gates_pipe: queue-based reference model checked every
// cycle, a table of opcode/accumulate vectors, and hand-written corner sequences.
module tb_gates_pipe;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 2;
    localparam int CW     = $clog2(DEPTH+1);
    localparam int N_WRAP = 25;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic [CW-1:0]    count;

    gates_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .acc_en    (acc_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .zero      (zero),
        .parity    (parity),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             acc_en;
        logic [WIDTH-1:0] exp_y;
        logic             exp_zero;
    } vec_t;

    vec_t vecs[10];

    logic [WIDTH-1:0] mdl_q[$];
    logic [WIDTH-1:0] mdl_acc;
    logic [WIDTH-1:0] exp_log[$];
    logic [WIDTH-1:0] dut_log[$];

    function automatic logic [WIDTH-1:0] ref_op(input int o, input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] z);
        case (o)
            0:       return x & z;
            1:       return x | z;
            2:       return ~x;
            3:       return x ^ z;
            4:       return ~(x & z);
            5:       return ~(x | z);
            6:       return ~(x ^ z);
            default: return z;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic [2:0] ov, input logic ae);
        in_valid = v;
        a        = av;
        b        = bv;
        op       = ov;
        acc_en   = ae;
    endtask

    // Reference model: a plain queue of results bounded at DEPTH entries.
    always @(posedge clk) begin : model
        int               sz;
        logic [WIDTH-1:0] res;
        sz = mdl_q.size();
        if (rst) begin
            mdl_q.delete();
            mdl_acc = '0;
        end else begin
            res = ref_op(int'(op), acc_en ? mdl_acc : a, b);
            if (out_ready && sz > 0) void'(mdl_q.pop_front());
            if (in_valid && sz < DEPTH) begin
                mdl_q.push_back(res);
                exp_log.push_back(res);
                mdl_acc = res;
            end
        end
    end

    always @(negedge clk) begin : monitor
        logic [WIDTH-1:0] hy;
        if (chk_en) begin
            hy = (mdl_q.size() > 0) ? mdl_q[0] : '0;
            checkOutput("mon_in_ready", in_ready, mdl_q.size() < DEPTH);
            checkOutput("mon_out_valid", out_valid, mdl_q.size() > 0);
            checkOutput("mon_count", count, mdl_q.size());
            checkOutput("mon_y", y, hy);
            checkOutput("mon_zero", zero, (mdl_q.size() > 0) && (hy == '0));
            checkOutput("mon_parity", parity, (mdl_q.size() > 0) && (^hy));
            if (!rst && out_valid && out_ready) dut_log.push_back(y);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int accepted;
        int cyc;

        vecs[0] = '{3'd0, 8'hA5, 8'h3C, 1'b0, 8'h24, 1'b0};
        vecs[1] = '{3'd1, 8'hA5, 8'h3C, 1'b0, 8'hBD, 1'b0};
        vecs[2] = '{3'd2, 8'hA5, 8'h3C, 1'b0, 8'h5A, 1'b0};
        vecs[3] = '{3'd3, 8'hA5, 8'h3C, 1'b0, 8'h99, 1'b0};
        vecs[4] = '{3'd4, 8'hA5, 8'h3C, 1'b0, 8'hDB, 1'b0};
        vecs[5] = '{3'd5, 8'hA5, 8'h3C, 1'b0, 8'h42, 1'b0};
        vecs[6] = '{3'd6, 8'hA5, 8'h3C, 1'b0, 8'h66, 1'b0};
        vecs[7] = '{3'd7, 8'hA5, 8'h3C, 1'b0, 8'h3C, 1'b0};
        vecs[8] = '{3'd1, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0};
        vecs[9] = '{3'd3, 8'h12, 8'hFF, 1'b1, 8'h00, 1'b1};

        rst = 1'b1;
        out_ready = 1'b0;
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b0);
        tick();
        tick();
        chk_en = 1'b1;
        rst = 1'b0;
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_y", y, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_zero", zero, 0);
        checkOutput("rst_parity", parity, 0);

        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].acc_en);
            tick();
            checkOutput("tbl_valid", out_valid, 1);
            checkOutput("tbl_y", y, vecs[i].exp_y);
            checkOutput("tbl_zero", zero, vecs[i].exp_zero);
            checkOutput("tbl_parity", parity, ^vecs[i].exp_y);
        end
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b0);
        tick();
        checkOutput("empty_valid", out_valid, 0);
        checkOutput("empty_y", y, 0);
        checkOutput("empty_zero", zero, 0);
        checkOutput("empty_parity", parity, 0);

        out_ready = 1'b0;
        applyStimulus(1'b1, 8'h01, 8'h02, 3'd1, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h10, 8'h20, 3'd3, 1'b0);
        tick();
        checkOutput("mid_count_full", count, 2);
        checkOutput("mid_in_ready_full", in_ready, 0);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid_rst_count", count, 0);
        checkOutput("mid_rst_valid", out_valid, 0);
        checkOutput("mid_rst_in_ready", in_ready, 1);
        out_ready = 1'b0;
        applyStimulus(1'b1, 8'h55, 8'h00, 3'd1, 1'b1);
        tick();
        checkOutput("acc_cleared_y", y, 8'h00);
        checkOutput("acc_cleared_zero", zero, 1);
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b0);
        out_ready = 1'b1;
        tick();
        checkOutput("acc_drain_count", count, 0);

        out_ready = 1'b0;
        applyStimulus(1'b1, '0, 8'h11, 3'd7, 1'b0);
        tick();
        applyStimulus(1'b1, '0, 8'h22, 3'd7, 1'b0);
        tick();
        checkOutput("bp_count", count, 2);
        checkOutput("bp_in_ready", in_ready, 0);
        applyStimulus(1'b1, '0, 8'h33, 3'd7, 1'b0);
        tick();
        checkOutput("bp_held_count", count, 2);
        checkOutput("bp_held_y", y, 8'h11);
        out_ready = 1'b1;
        tick();
        checkOutput("bp_pop1_y", y, 8'h22);
        checkOutput("bp_pop1_count", count, 1);
        tick();
        checkOutput("bp_third_y", y, 8'h33);
        checkOutput("bp_third_count", count, 1);
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b0);
        tick();
        checkOutput("bp_drained", out_valid, 0);

        out_ready = 1'b0;
        applyStimulus(1'b1, '0, 8'h80, 3'd7, 1'b0);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, '0, 8'h90 + WIDTH'(i), 3'd7, 1'b0);
            tick();
            checkOutput("pp_count", count, 1);
            checkOutput("pp_y", y, 8'h90 + i);
        end
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b0);
        tick();
        checkOutput("pp_drained", out_valid, 0);

        exp_log.delete();
        dut_log.delete();
        accepted = 0;
        cyc = 0;
        while (accepted < N_WRAP && cyc < 2000) begin
            applyStimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom),
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            out_ready = 1'($urandom_range(0, 1));
            if (in_valid && in_ready) accepted++;
            tick();
            cyc++;
        end
        applyStimulus(1'b0, '0, '0, 3'd0, 1'b0);
        out_ready = 1'b1;
        while (out_valid && cyc < 2000) begin
            tick();
            cyc++;
        end
        checkOutput("wrap_budget", cyc < 2000, 1);
        checkOutput("wrap_accepted", accepted, N_WRAP);
        checkOutput("wrap_pop_total", dut_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < dut_log.size(); i++)
            checkOutput("wrap_order", dut_log[i], exp_log[i]);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
